// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RISC-V instruction fetch front end with decode handshake
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7_5,
    output logic [31:0] PC,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ImmOp,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        FETCH    = 2'd1,
        ISSUE    = 2'd2,
        FAULT    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        fault_q;
    logic [31:0] next_pc;
    logic        misaligned;
    logic        retire;

    // Next PC only matters on retire; carries out of bit 31 are dropped.
    always_comb begin
        next_pc = pc_q + 32'd4;
        case (PCSrc)
            2'b01:   next_pc = pc_q + ImmOp;
            2'b10:   next_pc = ImmOp;
            default: next_pc = pc_q + 32'd4;
        endcase
    end

    assign misaligned = (next_pc[1:0] != 2'b00);
    assign retire     = (state == ISSUE) && instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RST_HOLD: state_nxt = FETCH;
            FETCH:    if (imem_ack) state_nxt = ISSUE;
            ISSUE:    if (instr_ready) state_nxt = misaligned ? FAULT : FETCH;
            FAULT:    state_nxt = FAULT;
            default:  state_nxt = RST_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            fault_q <= 1'b0;
        end else begin
            if ((state == FETCH) && imem_ack) begin
                instr_q <= imem_rdata;
            end
            // A bad target freezes PC at the retiring instruction's address.
            if (retire) begin
                if (misaligned) begin
                    fault_q <= 1'b1;
                end else begin
                    pc_q <= next_pc;
                end
            end
        end
    end

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state == ISSUE);
    assign instr       = instr_q;
    assign op          = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7_5    = instr_q[30];
    assign PC          = pc_q;
    assign fetch_fault = fault_q;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Front end of the RISC-V datapath and the producer side of the instruction-decode interface. It owns the program counter, fetches instruction words from a handshaked instruction memory, and presents each word and its `op`/`funct3`/`funct7_5` fields to the control unit through a valid/ready handshake. When an instruction retires, it takes back the `PCSrc` and `ImmOp` results and computes the next PC from them.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value after reset; must be word aligned.
- `NOP_WORD`, default `32'h0000_0013`: value held in the instruction register when no instruction is loaded (`addi x0,x0,0`).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; equals `PC`.
- `imem_ack`  in  1  memory accepted the request and returned data this cycle.
- `imem_rdata`  in  32  instruction word; valid only when `imem_ack`=1.
- `instr`  out  32  registered instruction word.
- `instr_valid`  out  1  `instr`, `op`, `funct3` and `funct7_5` are meaningful.
- `instr_ready`  in  1  downstream retires the instruction this cycle.
- `op`  out  7  `instr[6:0]`.
- `funct3`  out  3  `instr[14:12]`.
- `funct7_5`  out  1  `instr[30]`.
- `PC`  out  32  address of the current instruction.
- `PCSrc`  in  2  next-PC select from the control unit; sampled only on retire.
- `ImmOp`  in  32  immediate offset, or absolute target; sampled only on retire.
- `fetch_fault`  out  1  a misaligned target was computed; sticky until reset.

## Operation
- States:
  - RST_HOLD: `imem_req`=0.
  - FETCH: `imem_req`=1.
  - ISSUE: `instr_valid`=1.
  - FAULT: everything idle.
- Transitions:
  - RST_HOLD → FETCH unconditionally.
  - FETCH → ISSUE when `imem_ack`=1. In that same edge, `instr` ← `imem_rdata`.
  - ISSUE → FETCH when `instr_ready`=1, with `PC` ← next PC.
  - ISSUE → FAULT instead, if the next PC has bits [1:0] ≠ 0. In that case `PC` is not updated and `fetch_fault` ← 1.
  - FAULT is left only by `rst`.
- Next PC on retire:
  - `PCSrc`=00 → `PC`+4.
  - 01 → `PC`+`ImmOp` (branch taken / jal).
  - 10 → `ImmOp` (absolute target).
  - 11 → `PC`+4 (reserved).
- All additions are 32-bit modulo 2^32; carry out is discarded, so `32'hFFFF_FFFC`+4 = 0.
- Handshake rules:
  - `imem_req` stays high and `imem_addr` stays stable from entry to FETCH until the cycle `imem_ack`=1, inclusive.
  - `imem_ack` is ignored in every state except FETCH.
  - `instr_ready` is ignored unless in ISSUE.
  - `instr` and `PC` are stable for the whole of ISSUE.
  - `PCSrc` and `ImmOp` are sampled only in the ISSUE cycle where `instr_ready`=1. They may change freely at all other times.
- In FAULT: `imem_req`=0, `instr_valid`=0; `PC` holds the retired instruction's address.

## Timing
- Reset values, applied on any edge with `rst`=1 in any state (including mid-FETCH with a request outstanding):
  - state = RST_HOLD; `PC` = `RESET_PC`; `instr` = `NOP_WORD` (so `op`=`7'b0010011`, `funct3`=0, `funct7_5`=0).
  - `instr_valid`=0, `imem_req`=0, `fetch_fault`=0.
- A stale `imem_ack` arriving during RST_HOLD is discarded.
- Cycle numbering: cycle 0 is the first cycle with `rst`=0. State is RST_HOLD in cycle 0 and FETCH from cycle 1, so `imem_req` first rises in cycle 1.
- Latency:
  - Memory ack in the cycle it is requested → `instr_valid`=1 in the next cycle.
  - Retire (`instr_valid`&`instr_ready`) → `imem_req`=1 with the new `PC` in the next cycle.
  - Minimum throughput is 2 cycles per instruction; each extra memory wait cycle adds one.
- `instr_valid` drops in the cycle after retire. There is no back-to-back issue and no prefetch.
- `rst` has priority over every simultaneous event (ack, retire, fault).
- All outputs are registered or decoded combinationally from registers; there is no combinational path from any input to any output.

## Test plan
- Reset release with `RESET_PC`=0: `imem_req`=0 in cycle 0, 1 in cycle 1 with `imem_addr`=0. Ack in cycle 1 with `imem_rdata`=`32'h00A00093` → cycle 2: `instr_valid`=1, `op`=`7'h13`, `funct3`=0, `funct7_5`=0.
- Sequential flow and stalls:
  - Memory holds ack low for 3 cycles: `imem_req`/`imem_addr` stable throughout.
  - Retire with `PCSrc`=00 at `PC`=`32'h10` → next `imem_addr`=`32'h14`.
  - `instr_ready` held low for 5 cycles: `instr` and `PC` stable.
- Redirects:
  - `PC`=`32'h100`, `PCSrc`=01, `ImmOp`=`32'hFFFF_FFF0` → next `PC`=`32'hF0`.
  - `PCSrc`=10, `ImmOp`=`32'h200` → next `PC`=`32'h200`.
  - `PCSrc`=11 → `PC`+4.
- Wrap: `PC`=`32'hFFFF_FFFC`, `PCSrc`=00 → next `PC`=0 with no fault.
- Misaligned target: `PCSrc`=10, `ImmOp`=`32'h202` → `fetch_fault`=1 next cycle; `PC` unchanged; `imem_req`=0 and `instr_valid`=0 until `rst`.
- Reset mid-fetch: assert `rst` in a FETCH cycle while ack is pending, with ack arriving in that same cycle → next cycle `PC`=`RESET_PC`, `instr`=`NOP_WORD`, `instr_valid`=0, and the acked data is dropped.
